bitcoin_block_builder: RTL and testbench

BITCOIN_BLOCK_BUILDER -- requirements
Module: bitcoin_block_builder

---
 rtl/bitcoin_block_builder.sv | 146 ++++++++++++++
 tb/tb_bitcoin_block_builder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_block_builder.sv
// Fetches a 19-word block header, then feeds chunk 1 once and chunk 2 once per nonce to a
// downstream compression stage over a blk_start/blk_done handshake; NONCE_BYTESWAP_EN byte-reverses w3.
module bitcoin_block_builder (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  header_addr,
  input  logic [31:0]  nonce_base,
  input  logic [15:0]  nonce_count,
  output logic [15:0]  mem_addr,
  output logic         mem_re,
  input  logic [31:0]  mem_rdata,
  output logic         blk_start,
  input  logic         blk_done,
  output logic         blk_phase,
  output logic [511:0] block,
  output logic [31:0]  nonce,
  output logic         busy,
  output logic         done
);

  localparam logic [4:0] HDR_WORDS = 5'd19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BLK0  = 3'd2,
    ACK0  = 3'd3,
    BLK1  = 3'd4,
    ACK1  = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       rem_q, rem_d;
  logic [31:0]       nonce_q, nonce_d;
  logic              done_q, done_d;
  logic [18:0][31:0] hdr_q, hdr_d;
  logic [31:0]       nonce_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      nonce_q <= '0;
      done_q  <= 1'b0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      nonce_q <= nonce_d;
      done_q  <= done_d;
      hdr_q   <= hdr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    nonce_d = nonce_q;
    hdr_d   = hdr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nonce_count == 16'd0) begin
            state_d = FIN;
          end else begin
            addr_d  = header_addr;
            nonce_d = nonce_base;
            rem_d   = nonce_count;
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // Read data lags its strobe by one cycle, so word cnt-1 lands now.
        if (cnt_q != 5'd0) begin
          hdr_d[cnt_q - 5'd1] = mem_rdata;
        end
        if (cnt_q == HDR_WORDS) begin
          cnt_d   = '0;
          state_d = BLK0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      BLK0: begin
        if (blk_done) state_d = ACK0;
      end
      ACK0: begin
        if (!blk_done) state_d = BLK1;
      end
      BLK1: begin
        if (blk_done) state_d = ACK1;
      end
      ACK1: begin
        if (!blk_done) begin
          rem_d   = rem_q - 16'd1;
          nonce_d = nonce_q + 32'd1;
          state_d = (rem_q == 16'd1) ? FIN : BLK1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef NONCE_BYTESWAP_EN
    nonce_word = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
`else
    nonce_word = nonce_q;
`endif
    mem_re    = (state_q == FETCH) && (cnt_q < HDR_WORDS);
    mem_addr  = mem_re ? (addr_q + {11'd0, cnt_q}) : 16'd0;
    blk_start = (state_q == BLK0) || (state_q == BLK1);
    blk_phase = (state_q == BLK1) || (state_q == ACK1);
    busy      = (state_q != IDLE);
    done      = done_q;
    nonce     = nonce_q;
    // Outputs derive only from registers that are frozen while blk_start is high.
    if (blk_phase) begin
      block            = '0;
      block[95:0]      = {hdr_q[18], hdr_q[17], hdr_q[16]};
      block[127:96]    = nonce_word;
      block[159:128]   = 32'h8000_0000;
      block[511:480]   = 32'h0000_0280;
    end else begin
      block = hdr_q[15:0];
    end
  end

endmodule

// File: tb/tb_bitcoin_block_builder.sv
// Directed and random jobs against a memory model, a blk_done responder and a queue-based reference.
module tb_bitcoin_block_builder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  header_addr = '0;
  logic [31:0]  nonce_base = '0;
  logic [15:0]  nonce_count = '0;
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic [31:0]  mem_rdata = '0;
  logic         blk_start;
  logic         blk_done = 1'b0;
  logic         blk_phase;
  logic [511:0] block;
  logic [31:0]  nonce;
  logic         busy;
  logic         done;

  bitcoin_block_builder dut (
    .clk(clk), .reset(reset), .start(start), .header_addr(header_addr),
    .nonce_base(nonce_base), .nonce_count(nonce_count), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .blk_start(blk_start),
    .blk_done(blk_done), .blk_phase(blk_phase), .block(block), .nonce(nonce),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:65535];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  // Downstream stage: raise blk_done dly cycles into a request, hold it for hold cycles.
  int dly = 3, hold = 1, wcnt = 0, hcnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      blk_done <= 1'b0; wcnt <= 0; hcnt <= 0;
    end else if (!blk_done) begin
      if (blk_start) begin
        if (wcnt + 1 >= dly) begin blk_done <= 1'b1; wcnt <= 0; hcnt <= 0; end
        else wcnt <= wcnt + 1;
      end else wcnt <= 0;
    end else begin
      if (hcnt + 1 >= hold) blk_done <= 1'b0;
      hcnt <= hcnt + 1;
    end
  end

  logic [15:0]  rd_q[$];
  logic [511:0] blk_q[$];
  logic         ph_q[$];
  logic [31:0]  nn_q[$];
  int           bs_cyc_q[$];
  int done_cnt = 0, done_cyc = 0, stab_err = 0, start_err = 0;
  logic prev_bs = 1'b0, prev_bd = 1'b0, prev_ph = 1'b0;
  logic [511:0] prev_blk = '0;
  logic [31:0]  prev_nn = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_bs <= 1'b0; prev_bd <= 1'b0;
    end else begin
      if (mem_re) rd_q.push_back(mem_addr);
      if (blk_start && !prev_bs) begin
        blk_q.push_back(block); ph_q.push_back(blk_phase);
        nn_q.push_back(nonce); bs_cyc_q.push_back(cyc);
      end
      if (blk_start && prev_bs && (block !== prev_blk || blk_phase !== prev_ph || nonce !== prev_nn))
        stab_err <= stab_err + 1;
      if (blk_start && blk_done && prev_bd) start_err <= start_err + 1;
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      prev_bs <= blk_start; prev_bd <= blk_done; prev_blk <= block;
      prev_ph <= blk_phase; prev_nn <= nonce;
    end
  end

  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w3_of(input logic [31:0] n);
`ifdef NONCE_BYTESWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  function automatic logic [511:0] exp_blk(input bit ph, input logic [15:0] ha, input logic [31:0] n);
    logic [511:0] b = '0;
    logic [15:0] a;
    if (!ph) begin
      for (int i = 0; i < 16; i++) begin a = ha + 16'(i); b[i*32 +: 32] = mem[a]; end
    end else begin
      for (int i = 0; i < 3; i++) begin a = ha + 16'(16 + i); b[i*32 +: 32] = mem[a]; end
      b[96 +: 32]  = w3_of(n);
      b[128 +: 32] = 32'h8000_0000;
      b[480 +: 32] = 32'h0000_0280;
    end
    return b;
  endfunction

  task automatic run_job(input string tag, input logic [15:0] ha, input logic [31:0] nb,
                         input logic [15:0] nc, input int d, input int h, input bit inj);
    int rd0, b0, dn0, se0, st0, t0, limit, nblk, bad;
    logic [31:0] n;
    logic [15:0] a;
    @(negedge clk);
    dly = d; hold = h;
    rd0 = rd_q.size(); b0 = blk_q.size(); dn0 = done_cnt; se0 = stab_err; st0 = start_err;
    header_addr = ha; nonce_base = nb; nonce_count = nc; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    header_addr = 16'($urandom); nonce_base = $urandom; nonce_count = 16'($urandom);
    limit = 200 + int'(nc) * (2 * (d + h) + 10);
    for (int k = 0; k < limit && done_cnt == dn0; k++) begin
      @(negedge clk);
      start = inj && (k == 30);
    end
    start = 1'b0;
    check({tag, "_timeout"}, done_cnt == dn0, 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - dn0, 1);
    check({tag, "_busy_after"}, busy, 0);
    nblk = (nc == 0) ? 0 : 1 + int'(nc);
    check({tag, "_nblocks"}, blk_q.size() - b0, nblk);
    check({tag, "_nreads"}, rd_q.size() - rd0, (nc == 0) ? 0 : 19);
    check({tag, "_stable"}, stab_err - se0, 0);
    check({tag, "_start_in_done"}, start_err - st0, 0);
    if (nc == 0) begin
      check({tag, "_done_latency"}, done_cyc - t0, 2);
    end else begin
      bad = 0;
      for (int i = 0; i < 19 && rd0 + i < rd_q.size(); i++) begin
        a = ha + 16'(i);
        if (rd_q[rd0 + i] !== a) bad++;
      end
      check({tag, "_read_addrs"}, bad, 0);
      if (blk_q.size() >= b0 + nblk) begin
        check({tag, "_first_blk_cycle"}, bs_cyc_q[b0] - t0, 21);
        check({tag, "_blk0_phase"}, ph_q[b0], 0);
        check({tag, "_blk0_data"}, blk_q[b0], exp_blk(1'b0, ha, 32'd0));
        for (int k = 0; k < int'(nc); k++) begin
          n = nb + 32'(k);
          check($sformatf("%s_blk1_%0d_phase", tag, k), ph_q[b0 + 1 + k], 1);
          check($sformatf("%s_blk1_%0d_nonce", tag, k), nn_q[b0 + 1 + k], n);
          check($sformatf("%s_blk1_%0d_data", tag, k), blk_q[b0 + 1 + k], exp_blk(1'b1, ha, n));
        end
      end
    end
  endtask

  initial begin
    int b, dn0;
    logic [15:0] ha;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 19; i++) mem[16'h0040 + i] = 32'h1000_0000 + 32'(i);

    repeat (2) @(negedge clk);
    check("reset_ctrl_outs", {mem_addr, mem_re, blk_start, blk_phase, nonce, busy, done}, '0);
    check("reset_block", block, '0);
    reset = 1'b0;

    b = blk_q.size();
    run_job("basic", 16'h0040, 32'd5, 16'd1, 3, 1, 1'b0);
    check("basic_w0", blk_q[b][31:0], 32'h1000_0000);
    check("basic_w15", blk_q[b][511:480], 32'h1000_000F);
    check("basic_p1_w0", blk_q[b+1][31:0], 32'h1000_0010);
    check("basic_p1_w3", blk_q[b+1][127:96], w3_of(32'd5));

    run_job("wrap", 16'hFFF5, 32'hFFFF_FFFE, 16'd3, 2, 1, 1'b0);
    run_job("zero_count", 16'h0040, 32'd9, 16'd0, 3, 1, 1'b0);
    run_job("long_done", 16'h1234, 32'hA5A5_0000, 16'd2, 3, 4, 1'b1);

    // Abort a job during its second chunk-2 request, then run a clean job.
    @(negedge clk);
    dly = 6; hold = 1;
    b = blk_q.size(); dn0 = done_cnt;
    header_addr = 16'h0200; nonce_base = 32'd100; nonce_count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && blk_q.size() < b + 3; k++) @(negedge clk);
    check("midreset_reached", blk_q.size() >= b + 3, 1);
    #1 reset = 1'b1;
    #1;
    check("midreset_ctrl_outs", {mem_addr, mem_re, blk_start, blk_phase, nonce, busy, done}, '0);
    check("midreset_block", block, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset_no_done", done_cnt - dn0, 0);
    run_job("restart", 16'h0200, 32'd100, 16'd2, 2, 2, 1'b0);

    b = blk_q.size();
    run_job("swap", 16'h0300, 32'h1234_5678, 16'd1, 1, 1, 1'b0);
    check("swap_nonce_port", nn_q[b+1], 32'h1234_5678);
    check("swap_w3", blk_q[b+1][127:96], w3_of(32'h1234_5678));

    for (int r = 0; r < 4; r++) begin
      ha = 16'($urandom);
      run_job($sformatf("rand%0d", r), ha, $urandom, 16'($urandom_range(1, 4)),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
